// File: rtl/eigen_solve_2x2.sv
// Iterative eigen-solver for a general 2x2 signed fixed-point matrix.
// Real or complex-conjugate roots via a restoring square root, plus unnormalised eigenvectors.
module eigen_solve_2x2 #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0][1:0][WIDTH-1:0]    matrix,
  output logic                          busy,
  output logic                          done,
  output logic [1:0][WIDTH-1:0]         eigenvalues,
  output logic [WIDTH-1:0]              imag,
  output logic [1:0][1:0][WIDTH-1:0]    eigenvectors,
  output logic                          complex_roots,
  output logic                          sat
);

  localparam int NR = WIDTH + 1;      // root bits
  localparam int DW = 2 * WIDTH + 2;  // discriminant bits
  localparam int RW = NR + 2;         // partial remainder bits
  localparam int EW = WIDTH + 3;      // headroom for pre-saturation sums
  localparam int CW = $clog2(NR);
  localparam logic [CW-1:0]         LAST = CW'(NR - 1);
  localparam logic [WIDTH-1:0]      ONE  = WIDTH'(1 << FRAC);
  localparam logic signed [EW-1:0]  SMAX = EW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0]  SMIN = ~SMAX;

  typedef enum logic [2:0] {IDLE, LOAD, DISC, SQRT, VEC, DONE} state_t;

  typedef struct packed {
    logic             clip;
    logic [WIDTH-1:0] val;
  } sat_t;

  function automatic sat_t sat_f(input logic signed [EW-1:0] x);
    sat_t s;
    s.clip = 1'b0;
    s.val  = x[WIDTH-1:0];
    if (x > SMAX) begin
      s.clip = 1'b1;
      s.val  = SMAX[WIDTH-1:0];
    end else if (x < SMIN) begin
      s.clip = 1'b1;
      s.val  = SMIN[WIDTH-1:0];
    end
    return s;
  endfunction

  function automatic logic signed [EW-1:0] ext_w(input logic [WIDTH-1:0] x);
    return {{(EW - WIDTH){x[WIDTH-1]}}, x};
  endfunction

  state_t state_q, state_d;

  logic [WIDTH-1:0]        a_q, b_q, c_q, d_q;
  logic signed [WIDTH:0]   m_q, h_q;
  logic                    disc_neg_q;
  logic [DW-1:0]           rad_q;
  logic [RW-1:0]           rem_q;
  logic [NR-1:0]           root_q;
  logic [CW-1:0]           cnt_q;

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register is written with <= so all flops update from pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = DISC;
      DISC:    state_d = SQRT;
      SQRT:    if (cnt_q == LAST) state_d = VEC;
      VEC:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // ---------------- LOAD / DISC arithmetic ----------------
  logic signed [WIDTH:0]  sum_ad, dif_ad, m_d, h_d;
  logic signed [DW-1:0]   h_x, b_x, c_x, disc_d;
  logic [DW-1:0]          mag_d;

  assign sum_ad = {a_q[WIDTH-1], a_q} + {d_q[WIDTH-1], d_q};
  assign dif_ad = {a_q[WIDTH-1], a_q} - {d_q[WIDTH-1], d_q};
  assign m_d    = sum_ad >>> 1;
  assign h_d    = dif_ad >>> 1;

  assign h_x    = {{(DW - WIDTH - 1){h_q[WIDTH]}}, h_q};
  assign b_x    = {{(DW - WIDTH){b_q[WIDTH-1]}}, b_q};
  assign c_x    = {{(DW - WIDTH){c_q[WIDTH-1]}}, c_q};
  assign disc_d = h_x * h_x + b_x * c_x;
  assign mag_d  = disc_d[DW-1] ? -disc_d : disc_d;

  // ---------------- restoring square root, one root bit per cycle ----------------
  logic [RW-1:0] rem_sh, trial, rem_nx;
  logic [NR-1:0] root_nx;
  logic          ge;

  assign rem_sh  = {rem_q[RW-3:0], rad_q[DW-1:DW-2]};
  assign trial   = {root_q, 2'b01};
  // Top remainder bits are always clear; folding them in keeps the compare exact.
  assign ge      = (|rem_q[RW-1:RW-2]) | (rem_sh >= trial);
  assign rem_nx  = ge ? (rem_sh - trial) : rem_sh;
  assign root_nx = {root_q[NR-2:0], ge};

  // ---------------- VEC result formation ----------------
  logic signed [EW-1:0] m_e, r_e;
  sat_t lam0, lam1, mid, im_s, va0, va1, vd0, vd1;

  assign m_e  = {{(EW - WIDTH - 1){m_q[WIDTH]}}, m_q};
  assign r_e  = {2'b00, root_q};
  assign lam0 = sat_f(m_e - r_e);
  assign lam1 = sat_f(m_e + r_e);
  assign mid  = sat_f(m_e);
  assign im_s = sat_f(r_e);
  // Vector components use the already-saturated eigenvalues.
  assign va0  = sat_f(ext_w(lam0.val) - ext_w(a_q));
  assign va1  = sat_f(ext_w(lam1.val) - ext_w(a_q));
  assign vd0  = sat_f(ext_w(lam0.val) - ext_w(d_q));
  assign vd1  = sat_f(ext_w(lam1.val) - ext_w(d_q));

  logic [1:0][WIDTH-1:0]      ev_d;
  logic [WIDTH-1:0]           im_d;
  logic [1:0][1:0][WIDTH-1:0] vec_d;
  logic                       cr_d, sat_d;

  always_comb begin
    ev_d  = '0;
    im_d  = '0;
    vec_d = '0;
    cr_d  = 1'b0;
    sat_d = 1'b0;
    if (disc_neg_q) begin
      ev_d[0] = mid.val;
      ev_d[1] = mid.val;
      im_d    = im_s.val;
      cr_d    = 1'b1;
      sat_d   = mid.clip | im_s.clip;
    end else begin
      ev_d[0] = lam0.val;
      ev_d[1] = lam1.val;
      sat_d   = lam0.clip | lam1.clip;
      // eigenvectors[k][0] is x, eigenvectors[k][1] is y.
      if (b_q != '0) begin
        vec_d[0][0] = b_q;
        vec_d[0][1] = va0.val;
        vec_d[1][0] = b_q;
        vec_d[1][1] = va1.val;
        sat_d       = sat_d | va0.clip | va1.clip;
      end else if (c_q != '0) begin
        vec_d[0][0] = vd0.val;
        vec_d[0][1] = c_q;
        vec_d[1][0] = vd1.val;
        vec_d[1][1] = c_q;
        sat_d       = sat_d | vd0.clip | vd1.clip;
      end else if ($signed(a_q) <= $signed(d_q)) begin
        vec_d[0][0] = ONE;
        vec_d[1][1] = ONE;
      end else begin
        vec_d[0][1] = ONE;
        vec_d[1][0] = ONE;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state is reset so an aborted request leaves nothing stale behind.
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      m_q           <= '0;
      h_q           <= '0;
      disc_neg_q    <= 1'b0;
      rad_q         <= '0;
      rem_q         <= '0;
      root_q        <= '0;
      cnt_q         <= '0;
      eigenvalues   <= '0;
      imag          <= '0;
      eigenvectors  <= '0;
      complex_roots <= 1'b0;
      sat           <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          a_q <= matrix[0][0];
          b_q <= matrix[0][1];
          c_q <= matrix[1][0];
          d_q <= matrix[1][1];
        end
        LOAD: begin
          m_q <= m_d;
          h_q <= h_d;
        end
        DISC: begin
          disc_neg_q <= disc_d[DW-1];
          rad_q      <= mag_d;
          rem_q      <= '0;
          root_q     <= '0;
          cnt_q      <= '0;
        end
        SQRT: begin
          rad_q  <= {rad_q[DW-3:0], 2'b00};
          rem_q  <= rem_nx;
          root_q <= root_nx;
          cnt_q  <= cnt_q + 1'b1;
        end
        VEC: begin
          eigenvalues   <= ev_d;
          imag          <= im_d;
          eigenvectors  <= vec_d;
          complex_roots <= cr_d;
          sat           <= sat_d;
        end
        default: ;
      endcase
    end
  end

endmodule
